// File: rtl/av2_recon_frame_writer.sv
// Reconstruction frame writer: buffers decoder recon writes in a FWFT FIFO and drains them to the
// frame store over valid/ready. Optional pixel checksum enabled by defining AV2_RECON_CHECKSUM_EN.
module av2_recon_frame_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             frame_base,
  input  logic [DATA_W-1:0]             recon_data,
  input  logic [ADDR_W-1:0]             recon_addr,
  input  logic                          recon_wr_en,
  input  logic                          tile_done,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  output logic [DATA_W-1:0]             mem_wr_data,
  output logic                          mem_wr_valid,
  input  logic                          mem_wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   write_count,
  output logic                          frame_done,
  output logic [31:0]                   checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              empty, full, pop, push_req, push;
  logic [ADDR_W-1:0] addr_sum_p0, push_addr_p0;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign pop      = !empty && mem_wr_ready;
  // A write in the start cycle belongs to the discarded frame.
  assign push_req = recon_wr_en && !start && (state == ACTIVE || state == DRAIN);
  assign push     = push_req && (!full || pop);

  assign addr_sum_p0  = base_q + recon_addr;
  assign push_addr_p0 = {addr_sum_p0[ADDR_W-1:4], 4'b0000};

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // DRAIN ends on the cycle whose pop leaves the FIFO empty, so frame_done follows the last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      ACTIVE:  if (tile_done) state_nxt = DRAIN;
      DRAIN:   if (level_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = ACTIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base_q      <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      write_count <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        base_q      <= frame_base;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        level       <= '0;
        overflow    <= 1'b0;
        write_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        level <= level_nxt;
        if (push_req && !push) overflow <= 1'b1;
        if (push) write_count <= sat_inc16(write_count);
      end
    end
  end

  // ---- storage stage: entries carry no reset, outputs are masked while empty ----
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr_p0;
      data_mem[wr_ptr] <= recon_data;
    end
  end

  assign mem_wr_valid = !empty;
  assign mem_wr_addr  = empty ? '0 : addr_mem[rd_ptr];
  assign mem_wr_data  = empty ? '0 : data_mem[rd_ptr];
  assign fifo_level   = level;
  assign frame_done   = (state == DONE);

`ifdef AV2_RECON_CHECKSUM_EN
  function automatic logic [31:0] byte_sum(input logic [DATA_W-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < DATA_W / 8; j++) s = s + {24'd0, w[j*8 +: 8]};
    return s;
  endfunction

  logic [31:0] checksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     checksum_q <= '0;
    else if (start) checksum_q <= '0;
    else if (push)  checksum_q <= checksum_q + byte_sum(recon_data);
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_av2_recon_frame_writer.sv
// Bench for av2_recon_frame_writer: directed table, multi-cycle corner sequences and random traffic
// checked against a queue-based model of the writer.
module tb_av2_recon_frame_writer;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int DW    = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, recon_wr_en, tile_done, mem_wr_ready;
  logic [AW-1:0] frame_base, recon_addr, mem_wr_addr;
  logic [DW-1:0] recon_data, mem_wr_data;
  logic          mem_wr_valid, overflow, frame_done;
  logic [4:0]    fifo_level;
  logic [15:0]   write_count;
  logic [31:0]   checksum;

  av2_recon_frame_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_base(frame_base),
    .recon_data(recon_data), .recon_addr(recon_addr), .recon_wr_en(recon_wr_en),
    .tile_done(tile_done), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .fifo_level(fifo_level),
    .overflow(overflow), .write_count(write_count), .frame_done(frame_done),
    .checksum(checksum)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mq[$];
  int            m_phase;  // 0 idle, 1 active, 2 drain, 3 done
  logic [AW-1:0] m_base;
  bit            m_ov;
  int            m_cnt;
  logic [31:0]   m_cks;
  logic [AW-1:0] beat_addr[$];
  logic [DW-1:0] beat_data[$];

  function automatic logic [31:0] bytes_sum(input logic [DW-1:0] w);
    logic [31:0] s;
    s = 0;
    for (int j = 0; j < DW / 8; j++) s += 32'(w[j*8 +: 8]);
    return s;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_base  = 0;
    m_ov    = 0;
    m_cnt   = 0;
    m_cks   = 0;
  endtask

  task automatic model_edge();
    entry_t e;
    bit     popped;
    popped = (mq.size() > 0) && mem_wr_ready;
    if (start) begin
      mq.delete();
      m_cnt   = 0;
      m_ov    = 0;
      m_cks   = 0;
      m_base  = frame_base;
      m_phase = 1;
      return;
    end
    if (popped) void'(mq.pop_front());
    if ((m_phase == 1 || m_phase == 2) && recon_wr_en) begin
      if (mq.size() < DEPTH) begin
        e.addr = (m_base + recon_addr) & 32'hFFFF_FFF0;
        e.data = recon_data;
        mq.push_back(e);
        if (m_cnt < 65535) m_cnt++;
        m_cks += bytes_sum(recon_data);
      end else begin
        m_ov = 1;
      end
    end
    case (m_phase)
      1: if (tile_done) m_phase = 2;
      2: if (mq.size() == 0) m_phase = 3;
      3: m_phase = 0;
      default: ;
    endcase
  endtask

  task automatic compare_model();
    logic [31:0] exp_cks;
`ifdef AV2_RECON_CHECKSUM_EN
    exp_cks = m_cks;
`else
    exp_cks = 32'h0;
`endif
    check("m_valid", mem_wr_valid, mq.size() > 0);
    check("m_level", fifo_level, mq.size());
    if (mq.size() > 0) begin
      check("m_addr", mem_wr_addr, mq[0].addr);
      check("m_data", mem_wr_data, mq[0].data);
    end else begin
      check("m_addr_idle", mem_wr_addr, 0);
      check("m_data_idle", mem_wr_data, 0);
    end
    check("m_overflow", overflow, m_ov);
    check("m_count", write_count, m_cnt);
    check("m_done", frame_done, m_phase == 3);
    check("m_checksum", checksum, exp_cks);
  endtask

  task automatic tick();
    if (mem_wr_valid && mem_wr_ready) begin
      beat_addr.push_back(mem_wr_addr);
      beat_data.push_back(mem_wr_data);
    end
    model_edge();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    start      = 1'b1;
    frame_base = base;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    recon_wr_en = 1'b1;
    recon_addr  = addr;
    recon_data  = data;
    tick();
    recon_wr_en = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            st;
    logic [AW-1:0] fb;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            td;
    bit            rdy;
    bit            e_valid;
    int            e_level;
    logic [AW-1:0] e_addr;
    bit            e_ov;
    int            e_cnt;
    bit            e_done;
  } vec_t;

  vec_t tbl[11];

  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  bit            got_done;
  logic [31:0]   exp_t6;

  initial begin
    tbl[0]  = '{1, 32'h1000,      0, 0,      0,      0, 0, 0, 0, 0,           0, 0, 0};
    tbl[1]  = '{0, 0,             1, 32'h20, 128'hA, 0, 0, 1, 1, 32'h1020,    0, 1, 0};
    tbl[2]  = '{0, 0,             1, 32'h35, 128'hB, 0, 0, 1, 2, 32'h1020,    0, 2, 0};
    tbl[3]  = '{0, 0,             0, 0,      0,      1, 1, 1, 1, 32'h1030,    0, 2, 0};
    tbl[4]  = '{0, 0,             0, 0,      0,      0, 1, 0, 0, 0,           0, 2, 1};
    tbl[5]  = '{0, 0,             0, 0,      0,      0, 1, 0, 0, 0,           0, 2, 0};
    tbl[6]  = '{0, 0,             1, 32'h40, 128'hC, 0, 1, 0, 0, 0,           0, 2, 0};
    tbl[7]  = '{1, 32'hFFFF_FFF8, 0, 0,      0,      0, 1, 0, 0, 0,           0, 0, 0};
    tbl[8]  = '{0, 0,             1, 32'h10, 128'hD, 0, 0, 1, 1, 32'h0,       0, 1, 0};
    tbl[9]  = '{0, 0,             0, 0,      0,      1, 1, 0, 0, 0,           0, 1, 0};
    tbl[10] = '{0, 0,             0, 0,      0,      0, 1, 0, 0, 0,           0, 1, 1};

    rst_n = 1'b0; start = 1'b0; frame_base = '0; recon_data = '0; recon_addr = '0;
    recon_wr_en = 1'b0; tile_done = 1'b0; mem_wr_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", mem_wr_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", write_count, 0);
    check("rst_done", frame_done, 0);
    check("rst_checksum", checksum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].st; frame_base = tbl[i].fb; recon_wr_en = tbl[i].wr;
      recon_addr = tbl[i].addr; recon_data = tbl[i].data; tile_done = tbl[i].td;
      mem_wr_ready = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), mem_wr_valid, tbl[i].e_valid);
      check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].e_level);
      if (tbl[i].e_valid) check($sformatf("tbl%0d_addr", i), mem_wr_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].e_ov);
      check($sformatf("tbl%0d_count", i), write_count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_done", i), frame_done, tbl[i].e_done);
    end
    start = 0; recon_wr_en = 0; tile_done = 0;

    // Full frame streamed with ready held high.
    do_start(32'h1000);
    mem_wr_ready = 1'b1;
    beat_addr.delete(); beat_data.delete();
    for (int i = 0; i < 256; i++) begin
      recon_wr_en = 1'b1; recon_addr = 32'(16 * i); recon_data = DW'(i);
      tile_done = (i == 255);
      tick();
    end
    recon_wr_en = 1'b0; tile_done = 1'b0;
    tick();
    check("t1_done_after_last", frame_done, 1);
    check("t1_beats", beat_addr.size(), 256);
    for (int k = 0; k < beat_addr.size(); k++)
      if (beat_addr[k] !== 32'h1000 + 32'(16 * k)) check($sformatf("t1_addr%0d", k), beat_addr[k], 32'h1000 + 32'(16 * k));
    check("t1_count", write_count, 256);
    check("t1_overflow", overflow, 0);
    tick();
    check("t1_done_single", frame_done, 0);

    // Overflow with memory stalled, then drain.
    do_start(32'h0);
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 20; k++) push_word(32'(16 * k), DW'(k));
    check("t2_level", fifo_level, 16);
    check("t2_overflow", overflow, 1);
    check("t2_count", write_count, 16);
    beat_addr.delete(); beat_data.delete();
    mem_wr_ready = 1'b1; tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      tick();
      got_done = frame_done;
    end
    check("t2_done_seen", got_done, 1);
    check("t2_beats", beat_data.size(), 16);
    for (int k = 0; k < beat_data.size(); k++)
      check($sformatf("t2_word%0d", k), beat_data[k], DW'(k));

    // Full FIFO with simultaneous push and pop.
    do_start(32'h0);
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 16; k++) push_word(32'(16 * k), DW'(k + 50));
    check("t3_full", fifo_level, 16);
    mem_wr_ready = 1'b1;
    push_word(32'h200, DW'(99));
    mem_wr_ready = 1'b0;
    check("t3_level", fifo_level, 16);
    check("t3_overflow", overflow, 0);
    check("t3_count", write_count, 17);

    // Drain with toggling ready and held outputs.
    do_start(32'h2000);
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(32'(16 * k), DW'(k + 100));
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    beat_addr.delete(); beat_data.delete();
    got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      mem_wr_ready = (c % 2 == 1);
      pa = mem_wr_addr; pd = mem_wr_data;
      tick();
      if (!mem_wr_ready && mem_wr_valid) begin
        check("t4_addr_stable", mem_wr_addr, pa);
        check("t4_data_stable", mem_wr_data, pd);
      end
      if (frame_done) begin
        check("t4_beats_at_done", beat_addr.size(), 5);
        got_done = 1;
      end
    end
    check("t4_done_seen", got_done, 1);
    for (int k = 0; k < beat_addr.size(); k++)
      check($sformatf("t4_addr%0d", k), beat_addr[k], 32'h2000 + 32'(16 * k));
    mem_wr_ready = 1'b0;

    // Restart in the middle of a drain.
    do_start(32'h3000);
    for (int k = 0; k < 3; k++) push_word(32'(16 * k), DW'(k + 7));
    tile_done = 1'b1;
    tick();
    tile_done = 1'b0;
    do_start(32'h4000);
    check("t5_valid", mem_wr_valid, 0);
    check("t5_level", fifo_level, 0);
    check("t5_count", write_count, 0);
    check("t5_overflow", overflow, 0);
    push_word(32'h30, DW'(1));
    check("t5_active_push", fifo_level, 1);
    check("t5_new_base", mem_wr_addr, 32'h4030);

    // Checksum of two all-0x80 words.
    do_start(32'h0);
    push_word(32'h0, {16{8'h80}});
    push_word(32'h10, {16{8'h80}});
`ifdef AV2_RECON_CHECKSUM_EN
    exp_t6 = 32'h1000;
`else
    exp_t6 = 32'h0;
`endif
    check("t6_checksum", checksum, exp_t6);

    // Asynchronous reset while words are queued.
    do_start(32'h5000);
    for (int k = 0; k < 3; k++) push_word(32'(16 * k), DW'(k));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", mem_wr_valid, 0);
    check("ar_level", fifo_level, 0);
    check("ar_count", write_count, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic.
    for (int blk = 0; blk < 6; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int c = 0; c < 500; c++) begin
        start       = (m_phase == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
        frame_base  = $urandom;
        recon_wr_en = ($urandom_range(0, 2) != 0);
        recon_addr  = $urandom;
        recon_data  = {$urandom, $urandom, $urandom, $urandom};
        tile_done   = ($urandom_range(0, 59) == 0);
        mem_wr_ready = ($urandom_range(0, 99) < rdy_pct);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
